// File: rtl/receive_keypoints_if.sv
`default_nettype none
// ============================================================================
//  Module   : receive_keypoints_if
//  Purpose  : Control/status and BRAM write bus of the UART keypoint receiver.
//  Revision : 1.0 - initial release
// ============================================================================
interface receive_keypoints_if #(
    parameter int BRAM_LENGTH = 1000,
    parameter int BIT_DEPTH   = 13
);
    localparam int c_ADDR_W = (BRAM_LENGTH > 1) ? $clog2(BRAM_LENGTH) : 1;

    logic                arm;
    logic                rx;
    logic [c_ADDR_W-1:0] address;
    logic [BIT_DEPTH-1:0] wdata;
    logic                we;
    logic                busy;
    logic                done;
    logic                frame_err;

    modport master (
        input  arm, rx,
        output address, wdata, we, busy, done, frame_err
    );

    modport slave (
        output arm, rx,
        input  address, wdata, we, busy, done, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/receive_keypoints.sv
`default_nettype none
// ============================================================================
//  Module   : receive_keypoints
//  Purpose  : 8N1 UART receiver packing byte pairs into BRAM words per transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module receive_keypoints #(
    parameter int BRAM_LENGTH     = 1000,
    parameter int BIT_DEPTH       = 13,
    parameter int CLOCKS_PER_BAUD = 50
) (
    input  logic                clk,
    input  logic                rst_in_n,
    receive_keypoints_if.master bus
);
    localparam int c_ADDR_W = (BRAM_LENGTH > 1) ? $clog2(BRAM_LENGTH) : 1;
    localparam int c_CNT_W  = $clog2(CLOCKS_PER_BAUD) + 1;
    localparam logic [c_CNT_W-1:0]  c_BAUD_LAST = c_CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [c_CNT_W-1:0]  c_HALF_LAST = c_CNT_W'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [c_ADDR_W-1:0] c_ADDR_LAST = c_ADDR_W'(BRAM_LENGTH - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {W_IDLE, W_UPPER, W_LOWER, W_DONE} word_state_t;

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [1:0]           r_sync_vld;
    logic                 r_rx_prev;
    rx_state_t            r_rx_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    word_state_t          r_state;
    logic [BIT_DEPTH-9:0] r_upper;
    logic [c_ADDR_W-1:0]  r_address;
    logic [BIT_DEPTH-1:0] r_wdata;
    logic                 r_we;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_frame_err;

    logic w_start_edge;
    logic w_stop_sample;
    logic w_byte_ok;
    logic w_byte_bad;

    // r_rx_prev only follows the line once the sync chain holds real samples,
    // so a line held low across reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_sync_vld <= 2'b00;
            r_rx_prev  <= 1'b0;
        end else begin
            r_rx_meta  <= bus.rx;
            r_rx_sync  <= r_rx_meta;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            r_rx_prev  <= r_sync_vld[1] & r_rx_sync;
        end
    end

    assign w_start_edge  = r_rx_prev & ~r_rx_sync;
    assign w_stop_sample = (r_rx_state == RX_STOP) && (r_cnt == c_BAUD_LAST);
    assign w_byte_ok     = w_stop_sample &  r_rx_sync;
    assign w_byte_bad    = w_stop_sample & ~r_rx_sync;

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_rx_state <= RX_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (w_start_edge) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt      <= '0;
                        r_bit_idx  <= '0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == c_BAUD_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_cnt == c_BAUD_LAST) begin
                        r_cnt      <= '0;
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // The address advances the cycle after the write strobe so that
    // address/wdata stay put while we is high.
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_state     <= W_IDLE;
            r_upper     <= '0;
            r_address   <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_we        <= 1'b0;
            r_done      <= 1'b0;
            r_frame_err <= w_byte_bad;
            case (r_state)
                W_IDLE: begin
                    if (bus.arm) begin
                        r_state   <= W_UPPER;
                        r_busy    <= 1'b1;
                        r_address <= '0;
                    end
                end
                W_UPPER: begin
                    if (r_we) begin
                        r_address <= r_address + c_ADDR_W'(1);
                    end
                    if (w_byte_ok) begin
                        r_upper <= r_shift[BIT_DEPTH-9:0];
                        r_state <= W_LOWER;
                    end
                end
                W_LOWER: begin
                    if (w_byte_bad) begin
                        r_state <= W_UPPER;
                    end else if (w_byte_ok) begin
                        r_wdata <= {r_upper, r_shift};
                        r_we    <= 1'b1;
                        r_state <= (r_address == c_ADDR_LAST) ? W_DONE : W_UPPER;
                    end
                end
                W_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= W_IDLE;
                end
                default: r_state <= W_IDLE;
            endcase
        end
    end

    assign bus.address   = r_address;
    assign bus.wdata     = r_wdata;
    assign bus.we        = r_we;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_receive_keypoints.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_receive_keypoints
//  Purpose  : Self-checking bench for receive_keypoints against a transfer model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_receive_keypoints;
    localparam int c_CPB = 50;
    localparam int c_LEN = 4;
    localparam int c_BD  = 13;

    logic clk      = 1'b0;
    logic rst_in_n = 1'b0;

    receive_keypoints_if #(.BRAM_LENGTH(c_LEN), .BIT_DEPTH(c_BD)) bus ();

    receive_keypoints #(
        .BRAM_LENGTH    (c_LEN),
        .BIT_DEPTH      (c_BD),
        .CLOCKS_PER_BAUD(c_CPB)
    ) dut (
        .clk     (clk),
        .rst_in_n(rst_in_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Observed activity, collected away from the rising edge
    int   obs_addr[$];
    int   obs_data[$];
    int   done_cnt  = 0;
    int   ferr_cnt  = 0;
    logic prev_we   = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            obs_addr.push_back(int'(bus.address));
            obs_data.push_back(int'(bus.wdata));
            check("we_while_busy", {31'b0, bus.busy}, 32'd1);
            check("we_single_cycle", {31'b0, prev_we}, 32'd0);
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            check("done_busy_fall", {30'b0, prev_busy, bus.busy}, 32'd2);
            check("done_single_cycle", {31'b0, prev_done}, 32'd0);
        end
        if (bus.frame_err === 1'b1) ferr_cnt++;
        prev_we   = bus.we;
        prev_busy = bus.busy;
        prev_done = bus.done;
    end

    // Transfer-level reference model
    int m_busy = 0, m_have = 0, m_upper = 0, m_addr = 0, m_done = 0, m_ferr = 0;
    int exp_addr[$];
    int exp_data[$];
    int n_compared = 0;

    task automatic model_arm();
        if (m_busy == 0) begin
            m_busy = 1;
            m_addr = 0;
            m_have = 0;
        end
    endtask

    task automatic model_byte(input int b, input bit good);
        if (!good) begin
            m_ferr++;
            m_have = 0;
        end else if (m_busy != 0) begin
            if (m_have == 0) begin
                m_upper = b;
                m_have  = 1;
            end else begin
                exp_addr.push_back(m_addr);
                exp_data.push_back(((m_upper * 256) + b) % (1 << c_BD));
                m_have = 0;
                if (m_addr == c_LEN - 1) begin
                    m_busy = 0;
                    m_done++;
                end else begin
                    m_addr++;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_have = 0;
        m_addr = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good, input int gap);
        @(negedge clk) bus.rx = 1'b0;
        repeat (c_CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (c_CPB) @(negedge clk);
        end
        bus.rx = good;
        repeat (c_CPB) @(negedge clk);
        bus.rx = 1'b1;
        repeat (c_CPB + gap) @(negedge clk);
    endtask

    task automatic tx(input int b, input bit good);
        send_byte(8'(b), good, 0);
        model_byte(b, good);
    endtask

    task automatic do_arm();
        @(negedge clk) bus.arm = 1'b1;
        @(negedge clk) bus.arm = 1'b0;
        model_arm();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":address"},   {30'b0, bus.address}, 32'd0);
        check({tag, ":wdata"},     {19'b0, bus.wdata},   32'd0);
        check({tag, ":we"},        {31'b0, bus.we},      32'd0);
        check({tag, ":busy"},      {31'b0, bus.busy},    32'd0);
        check({tag, ":done"},      {31'b0, bus.done},    32'd0);
        check({tag, ":frame_err"}, {31'b0, bus.frame_err}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_in_n = 1'b0;
        #1 check_reset_outputs(tag);
        repeat (3) @(negedge clk);
        rst_in_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        int lim;
        repeat (5) @(negedge clk);
        check({tag, ":busy"},      {31'b0, bus.busy},    32'(m_busy));
        check({tag, ":address"},   {30'b0, bus.address}, 32'(m_addr));
        check({tag, ":done_cnt"},  32'(done_cnt),        32'(m_done));
        check({tag, ":ferr_cnt"},  32'(ferr_cnt),        32'(m_ferr));
        check({tag, ":n_writes"},  32'(obs_addr.size()), 32'(exp_addr.size()));
        lim = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = n_compared; i < lim; i++) begin
            check($sformatf("%s:waddr[%0d]", tag, i), 32'(obs_addr[i]), 32'(exp_addr[i]));
            check($sformatf("%s:wdata[%0d]", tag, i), 32'(obs_data[i]), 32'(exp_data[i]));
        end
        if (lim > n_compared) n_compared = lim;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx  = 1'b1;
        bus.arm = 1'b0;
        #1 check_reset_outputs("reset_init");
        repeat (4) @(negedge clk);
        rst_in_n = 1'b1;
        repeat (5) @(negedge clk);
        check_state("idle_after_reset");

        // single word, transfer still open
        do_arm();
        tx(8'h12, 1'b1);
        tx(8'h34, 1'b1);
        check_state("one_word");

        // full transfer ending in done
        do_reset("reset_between");
        do_arm();
        tx(8'h00, 1'b1); tx(8'h01, 1'b1);
        tx(8'h00, 1'b1); tx(8'h02, 1'b1);
        tx(8'h00, 1'b1); tx(8'h03, 1'b1);
        tx(8'h1F, 1'b1); tx(8'hFF, 1'b1);
        check_state("full_transfer");

        // bytes while idle are dropped; top bits of upper byte dropped
        tx(8'h77, 1'b1);
        tx(8'h88, 1'b1);
        check_state("bytes_before_arm");
        do_arm();
        tx(8'hAB, 1'b1);
        tx(8'hCD, 1'b1);
        check_state("upper_truncate");

        // framing error restarts the word; short glitch is ignored
        do_reset("reset_before_ferr");
        do_arm();
        tx(8'h12, 1'b1);
        tx(8'h34, 1'b0);
        check_state("frame_error");
        tx(8'h56, 1'b1);
        @(negedge clk) bus.rx = 1'b0;
        repeat (10) @(negedge clk);
        bus.rx = 1'b1;
        repeat (100) @(negedge clk);
        check_state("glitch");
        tx(8'h78, 1'b1);
        check_state("after_ferr_word");

        // reset in the middle of the second word, line low at release
        do_reset("reset_before_mid");
        do_arm();
        tx(8'h11, 1'b1);
        tx(8'h22, 1'b1);
        tx(8'h33, 1'b1);
        fork
            send_byte(8'h44, 1'b1, 0);
            begin
                repeat (200) @(negedge clk);
                #2 rst_in_n = 1'b0;
                #1 check_reset_outputs("reset_mid_word");
            end
        join
        model_reset();
        bus.rx = 1'b0;
        @(negedge clk) rst_in_n = 1'b1;
        repeat (600) @(negedge clk);
        bus.rx = 1'b1;
        repeat (100) @(negedge clk);
        check_state("low_at_release");
        do_arm();
        tx(8'h05, 1'b1);
        tx(8'h06, 1'b1);
        check_state("after_mid_reset");

        // randomized traffic with occasional arms and framing errors
        do_reset("reset_before_random");
        do_arm();
        for (int k = 0; k < 24; k++) begin
            int  b;
            bit  good;
            int  gap;
            if ($urandom_range(0, 3) == 0) do_arm();
            b    = int'($urandom_range(0, 255));
            good = ($urandom_range(0, 9) != 0);
            gap  = int'($urandom_range(0, 40));
            send_byte(8'(b), good, gap);
            model_byte(b, good);
            if ((k % 4) == 3) check_state($sformatf("random_%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
